// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and CSR field constants for the pipeline trap controller
package pipe_ctrl_pkg;
   localparam int PCTL_XLEN = 32;
   localparam int MCAUSE_IRQ_BIT = PCTL_XLEN - 1;
   localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;
   typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP, MRET} pctl_state_e;
endpackage

// File: rtl/pipe_trap_ctrl_if.sv
// pipe_trap_ctrl_if: pipeline/CSR <-> sequencing controller bundle
//   master: pipeline/CSR side (drives PCs, hazards, CSR values; receives stall/flush/redirect/trap pulses)
//   slave : controller side
interface pipe_trap_ctrl_if #(
   parameter int XLEN = 32,
   parameter int CAUSE_W = 4
);
   logic [XLEN-1:0] pc_if;
   logic [XLEN-1:0] pc_ex;
   logic valid_ex;
   logic br_taken_ex;
   logic [XLEN-1:0] br_target_ex;
   logic rd_en_mw;
   logic mem_ready;
   logic is_mret_mw;
   logic irq_pending;
   logic [CAUSE_W-1:0] irq_cause;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mepc;
   logic stall_if;
   logic stall_mw;
   logic flush_ex;
   logic flush_mw;
   logic redirect;
   logic [XLEN-1:0] pc_target;
   logic trap_take;
   logic [XLEN-1:0] trap_epc;
   logic [XLEN-1:0] trap_cause;
   logic mret_take;
   modport master (
      output pc_if, pc_ex, valid_ex, br_taken_ex, br_target_ex, rd_en_mw, mem_ready,
             is_mret_mw, irq_pending, irq_cause, mtvec, mepc,
      input  stall_if, stall_mw, flush_ex, flush_mw, redirect, pc_target,
             trap_take, trap_epc, trap_cause, mret_take
   );
   modport slave (
      input  pc_if, pc_ex, valid_ex, br_taken_ex, br_target_ex, rd_en_mw, mem_ready,
             is_mret_mw, irq_pending, irq_cause, mtvec, mepc,
      output stall_if, stall_mw, flush_ex, flush_mw, redirect, pc_target,
             trap_take, trap_epc, trap_cause, mret_take
   );
endinterface

// File: rtl/trap_vec_gen.sv
// trap_vec_gen: mtvec/cause -> trap handler address (direct or vectored, wraps mod 2^XLEN)
//   mtvec in, cause in, target out
module trap_vec_gen
   import pipe_ctrl_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int CAUSE_W = 4
) (
   input  logic [XLEN-1:0] mtvec,
   input  logic [CAUSE_W-1:0] cause,
   output logic [XLEN-1:0] target
);
   logic [XLEN-1:0] base;
   always_comb begin
      base = {mtvec[XLEN-1:2], 2'b00};
      target = (mtvec[1:0] == MTVEC_MODE_VECTORED) ? base + (XLEN'(cause) << 2) : base;
   end
endmodule

// File: rtl/pipe_trap_ctrl.sv
// pipe_trap_ctrl: stall/flush/redirect sequencing with interrupt entry and mret return
//   clk, reset (sync, active-high), bus: pipe_trap_ctrl_if.slave
//   all bus outputs are Mealy decodes of state and inputs, forced to 0 while reset is high
module pipe_trap_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int XLEN = MCAUSE_IRQ_BIT + 1,
   parameter int CAUSE_W = 4
) (
   input  logic clk,
   input  logic reset,
   pipe_trap_ctrl_if.slave bus
);
   localparam int PAD = XLEN - 1 - CAUSE_W;
   pctl_state_e state;
   logic [CAUSE_W-1:0] cause_q;
   logic [XLEN-1:0] vec_target;
   logic run, ld, mr, tr, br, wait_stall, in_trap, in_mret;
   trap_vec_gen #(.XLEN(XLEN), .CAUSE_W(CAUSE_W)) u_vec (
      .mtvec(bus.mtvec),
      .cause(cause_q),
      .target(vec_target)
   );
   // priority in RUN: load stall > mret > interrupt > branch
   always_comb begin
      run = !reset && state == RUN;
      ld = run && bus.rd_en_mw && !bus.mem_ready;
      mr = run && !ld && bus.is_mret_mw;
      tr = run && !ld && !bus.is_mret_mw && bus.irq_pending;
      br = run && !ld && !bus.is_mret_mw && !bus.irq_pending && bus.br_taken_ex;
      wait_stall = !reset && state == MEM_WAIT && !bus.mem_ready;
      in_trap = !reset && state == TRAP;
      in_mret = !reset && state == MRET;
      bus.stall_if = ld || wait_stall;
      bus.stall_mw = ld || wait_stall;
      bus.flush_mw = mr || tr;
      bus.flush_ex = mr || tr || br || in_trap || in_mret;
      bus.redirect = br || in_trap || in_mret;
      bus.pc_target = in_mret ? bus.mepc : in_trap ? vec_target : br ? bus.br_target_ex : '0;
      bus.trap_take = tr;
      bus.trap_epc = !tr ? '0 : bus.valid_ex ? bus.pc_ex : bus.pc_if;
      bus.trap_cause = tr ? {1'b1, {PAD{1'b0}}, bus.irq_cause} : '0;
      bus.mret_take = mr;
   end
   always_ff @(posedge clk) begin
      state <= reset ? RUN : ld ? MEM_WAIT : mr ? MRET : tr ? TRAP : wait_stall ? MEM_WAIT : RUN;
      cause_q <= reset ? '0 : tr ? bus.irq_cause : cause_q;
   end
endmodule

// File: tb/tb_pipe_trap_ctrl.sv
// tb_pipe_trap_ctrl: directed-vector bench for pipe_trap_ctrl
module tb_pipe_trap_ctrl;
   import pipe_ctrl_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int vectors = 0;
   int miscompares = 0;
   pipe_trap_ctrl_if #(.XLEN(32), .CAUSE_W(4)) bus ();
   pipe_trap_ctrl #(.XLEN(32), .CAUSE_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask
   task automatic idle();
      bus.pc_if = 32'h0;
      bus.pc_ex = 32'h0;
      bus.valid_ex = 1'b0;
      bus.br_taken_ex = 1'b0;
      bus.br_target_ex = 32'h0;
      bus.rd_en_mw = 1'b0;
      bus.mem_ready = 1'b1;
      bus.is_mret_mw = 1'b0;
      bus.irq_pending = 1'b0;
      bus.irq_cause = 4'h0;
      bus.mtvec = 32'h0;
      bus.mepc = 32'h0;
   endtask
   // inputs change on the falling edge; outputs are checked 2 time units later
   task automatic next();
      @(negedge clk);
   endtask
   task automatic settle();
      #2;
   endtask
   task automatic check_quiet(input string tag);
      check({tag, ".stall_if"}, 32'(bus.stall_if), 32'd0);
      check({tag, ".stall_mw"}, 32'(bus.stall_mw), 32'd0);
      check({tag, ".flush_ex"}, 32'(bus.flush_ex), 32'd0);
      check({tag, ".flush_mw"}, 32'(bus.flush_mw), 32'd0);
      check({tag, ".redirect"}, 32'(bus.redirect), 32'd0);
      check({tag, ".pc_target"}, bus.pc_target, 32'h0);
      check({tag, ".trap_take"}, 32'(bus.trap_take), 32'd0);
      check({tag, ".trap_epc"}, bus.trap_epc, 32'h0);
      check({tag, ".trap_cause"}, bus.trap_cause, 32'h0);
      check({tag, ".mret_take"}, 32'(bus.mret_take), 32'd0);
   endtask
   initial begin
      idle();
      next();
      bus.irq_pending = 1'b1;
      bus.br_taken_ex = 1'b1;
      bus.br_target_ex = 32'h100;
      bus.rd_en_mw = 1'b1;
      bus.mem_ready = 1'b0;
      settle();
      check_quiet("in_reset");
      next();
      reset = 1'b0;
      idle();
      settle();
      check_quiet("after_reset");
      check("after_reset.state", 32'(dut.state), 32'(RUN));
      // branch
      next();
      bus.br_taken_ex = 1'b1;
      bus.br_target_ex = 32'h100;
      settle();
      check("br.redirect", 32'(bus.redirect), 32'd1);
      check("br.pc_target", bus.pc_target, 32'h100);
      check("br.flush_ex", 32'(bus.flush_ex), 32'd1);
      check("br.flush_mw", 32'(bus.flush_mw), 32'd0);
      next();
      idle();
      settle();
      check("br.state", 32'(dut.state), 32'(RUN));
      check("br.after_redirect", 32'(bus.redirect), 32'd0);
      // load stall for three cycles, irq ignored while waiting
      next();
      bus.rd_en_mw = 1'b1;
      bus.mem_ready = 1'b0;
      settle();
      check("ld.c0.stall_if", 32'(bus.stall_if), 32'd1);
      check("ld.c0.stall_mw", 32'(bus.stall_mw), 32'd1);
      next();
      bus.irq_pending = 1'b1;
      settle();
      check("ld.c1.stall_if", 32'(bus.stall_if), 32'd1);
      check("ld.c1.trap_take", 32'(bus.trap_take), 32'd0);
      next();
      bus.irq_pending = 1'b0;
      settle();
      check("ld.c2.stall_mw", 32'(bus.stall_mw), 32'd1);
      next();
      bus.mem_ready = 1'b1;
      settle();
      check("ld.rel.stall_if", 32'(bus.stall_if), 32'd0);
      check("ld.rel.stall_mw", 32'(bus.stall_mw), 32'd0);
      next();
      settle();
      check("ld.hit.stall_if", 32'(bus.stall_if), 32'd0);
      check("ld.hit.state", 32'(dut.state), 32'(RUN));
      // load stall outranks mret
      next();
      bus.mem_ready = 1'b0;
      bus.is_mret_mw = 1'b1;
      settle();
      check("ldmr.stall_if", 32'(bus.stall_if), 32'd1);
      check("ldmr.mret_take", 32'(bus.mret_take), 32'd0);
      next();
      idle();
      settle();
      check("ldmr.rel.stall_if", 32'(bus.stall_if), 32'd0);
      // direct trap
      next();
      bus.irq_pending = 1'b1;
      bus.irq_cause = 4'd7;
      bus.valid_ex = 1'b1;
      bus.pc_ex = 32'h40;
      bus.pc_if = 32'h44;
      bus.mtvec = 32'h200;
      settle();
      check("dt.trap_take", 32'(bus.trap_take), 32'd1);
      check("dt.trap_epc", bus.trap_epc, 32'h40);
      check("dt.trap_cause", bus.trap_cause, 32'h8000_0007);
      check("dt.flush_ex", 32'(bus.flush_ex), 32'd1);
      check("dt.flush_mw", 32'(bus.flush_mw), 32'd1);
      check("dt.redirect", 32'(bus.redirect), 32'd0);
      next();
      settle();
      check("dt.c1.redirect", 32'(bus.redirect), 32'd1);
      check("dt.c1.pc_target", bus.pc_target, 32'h200);
      check("dt.c1.flush_ex", 32'(bus.flush_ex), 32'd1);
      check("dt.c1.flush_mw", 32'(bus.flush_mw), 32'd0);
      check("dt.c1.trap_take", 32'(bus.trap_take), 32'd0);
      next();
      idle();
      settle();
      check("dt.c2.redirect", 32'(bus.redirect), 32'd0);
      // vectored trap with wrap; cause changes after entry to prove the latched cause is used
      next();
      bus.irq_pending = 1'b1;
      bus.irq_cause = 4'd7;
      bus.pc_if = 32'h1234;
      bus.pc_ex = 32'h5678;
      bus.mtvec = 32'hFFFF_FFF1;
      settle();
      check("vw.trap_epc", bus.trap_epc, 32'h1234);
      next();
      bus.irq_pending = 1'b0;
      bus.irq_cause = 4'd2;
      settle();
      check("vw.pc_target", bus.pc_target, 32'h0000_000C);
      next();
      bus.irq_pending = 1'b1;
      bus.irq_cause = 4'd5;
      bus.mtvec = 32'h301;
      settle();
      check("vn.trap_cause", bus.trap_cause, 32'h8000_0005);
      next();
      bus.irq_pending = 1'b0;
      settle();
      check("vn.pc_target", bus.pc_target, 32'h314);
      // mret, irq and branch together
      next();
      idle();
      bus.is_mret_mw = 1'b1;
      bus.irq_pending = 1'b1;
      bus.irq_cause = 4'd3;
      bus.br_taken_ex = 1'b1;
      bus.br_target_ex = 32'h500;
      bus.mepc = 32'h80;
      bus.mtvec = 32'h200;
      settle();
      check("sim.mret_take", 32'(bus.mret_take), 32'd1);
      check("sim.trap_take", 32'(bus.trap_take), 32'd0);
      check("sim.redirect", 32'(bus.redirect), 32'd0);
      check("sim.flush_mw", 32'(bus.flush_mw), 32'd1);
      next();
      bus.is_mret_mw = 1'b0;
      settle();
      check("sim.c1.redirect", 32'(bus.redirect), 32'd1);
      check("sim.c1.pc_target", bus.pc_target, 32'h80);
      check("sim.c1.trap_take", 32'(bus.trap_take), 32'd0);
      check("sim.c1.mret_take", 32'(bus.mret_take), 32'd0);
      next();
      bus.br_taken_ex = 1'b0;
      settle();
      check("sim.c2.trap_take", 32'(bus.trap_take), 32'd1);
      check("sim.c2.trap_cause", bus.trap_cause, 32'h8000_0003);
      // reset while in TRAP
      next();
      bus.irq_pending = 1'b0;
      reset = 1'b1;
      settle();
      check("rst.in_trap.redirect", 32'(bus.redirect), 32'd0);
      check("rst.in_trap.flush_ex", 32'(bus.flush_ex), 32'd0);
      next();
      reset = 1'b0;
      idle();
      settle();
      check("rst.state", 32'(dut.state), 32'(RUN));
      check_quiet("rst.after");
      next();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pipe_trap_ctrl.md
# pipe_trap_ctrl

Pipeline sequencing controller for the two-register (IF/EX, EX/MW) RISC-V core. It generates stall and flush controls for both pipeline registers and redirects the PC. It sequences machine-mode interrupt entry and `mret` return against the CSR file. It sits beside the EX/MW control register and is the only block allowed to bubble it.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- CAUSE_W, 4, width of the interrupt cause code

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- pc_if  in  XLEN  PC of the instruction being fetched
- pc_ex  in  XLEN  PC of the instruction in EX
- valid_ex  in  1  EX holds a real (non-bubble) instruction
- br_taken_ex  in  1  branch/jump resolved taken in EX
- br_target_ex  in  XLEN  branch/jump target
- rd_en_mw  in  1  load in MW
- mem_ready  in  1  data memory returns data this cycle
- is_mret_mw  in  1  `mret` in MW
- irq_pending  in  1  enabled interrupt pending (mip & mie & mstatus.MIE)
- irq_cause  in  CAUSE_W  cause code of the pending interrupt
- mtvec  in  XLEN  current mtvec value
- mepc  in  XLEN  current mepc value
- stall_if  out  1  hold PC and the IF/EX register
- stall_mw  out  1  hold the EX/MW register
- flush_ex  out  1  load a bubble into the IF/EX register
- flush_mw  out  1  load a bubble into the EX/MW register (all control bits 0)
- redirect  out  1  PC takes pc_target next edge
- pc_target  out  XLEN  redirect address
- trap_take  out  1  one-cycle pulse telling the CSR file to write mepc/mcause and clear MIE (MPIE := MIE)
- trap_epc  out  XLEN  value for mepc, valid with trap_take
- trap_cause  out  XLEN  value for mcause: {1'b1, zeros, irq_cause}
- mret_take  out  1  one-cycle pulse telling the CSR file to restore MIE := MPIE

## Operation
- States: RUN, MEM_WAIT, TRAP, MRET. Reset → RUN. All outputs are Mealy functions of state and inputs.
- Priority in RUN, highest first: load stall > `mret` > interrupt > branch.
- RUN, rd_en_mw & !mem_ready:
  - Assert stall_if and stall_mw.
  - Go to MEM_WAIT.
  - Nothing else is acted on this cycle.
- MEM_WAIT:
  - While !mem_ready, assert stall_if and stall_mw.
  - When mem_ready, release the stalls and go to RUN. Pending events are evaluated on the next cycle.
- RUN, is_mret_mw:
  - Assert mret_take, flush_ex and flush_mw to kill younger instructions.
  - Go to MRET.
- MRET:
  - Assert redirect with pc_target = mepc, and flush_ex.
  - Go to RUN.
- RUN, irq_pending with no higher-priority event:
  - Assert trap_take, flush_ex and flush_mw.
  - trap_epc = pc_ex if valid_ex, else pc_if.
  - Go to TRAP.
- TRAP:
  - Assert redirect and flush_ex.
  - If mtvec[1:0]==2'b01 (vectored), pc_target = {mtvec[XLEN-1:2],2'b00} + (cause_q << 2). Otherwise pc_target = {mtvec[XLEN-1:2],2'b00}.
  - cause_q is the cause registered when trap_take fired.
  - Go to RUN.
- RUN, br_taken_ex with no higher-priority event:
  - Assert redirect with pc_target = br_target_ex, and flush_ex.
  - Stay in RUN.
- irq_pending is ignored in MEM_WAIT, TRAP and MRET. It is re-sampled in RUN.
- Vector address arithmetic is modulo 2^XLEN and wraps silently.

## Timing
- Reset values: state RUN; cause_q 0; every output 0, including pc_target, trap_epc and trap_cause.
- Reset asserted in any state returns the block to RUN on the next edge. No pulse is emitted in that cycle.
- Stall and flush act at the same edge on which the controlled registers load.
  - Branch penalty: 1 bubble.
  - Trap entry or `mret`: 2 bubbles in IF/EX, 1 in EX/MW.
  - Redirect occurs 1 cycle after the decision.
- trap_take and mret_take are high for exactly one cycle per event.
- TRAP reads mtvec one cycle after trap_take, so a CSR write already in MW is visible.
- A load completing in the same cycle it enters MW (mem_ready=1) causes no stall.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - state enum `pctl_state_e`
  - constant `MCAUSE_IRQ_BIT = XLEN-1`
  - constant `MTVEC_MODE_VECTORED = 2'b01`
- One sub-module, `trap_vec_gen`: combinational mtvec/cause → target address computation.
- The FSM, cause_q and output decode stay in the top module.

## Test plan
- Branch: br_taken_ex=1, br_target_ex=0x100 in RUN → redirect=1, pc_target=0x100, flush_ex=1 in that cycle; state stays RUN.
- Load stall: rd_en_mw=1, mem_ready low for 3 cycles → stall_if=stall_mw=1 for exactly 3 cycles, released when mem_ready=1.
- Direct trap:
  - Stimulus: irq_pending=1, irq_cause=7, valid_ex=1, pc_ex=0x40, mtvec=0x200.
  - Cycle 0: trap_take=1, trap_epc=0x40, trap_cause=0x80000007, flush_ex=flush_mw=1.
  - Cycle 1: redirect=1, pc_target=0x200.
- Vectored trap with wrap: mtvec=0xFFFFFFF1, cause 7 → pc_target=0x0000000C.
- Simultaneous events:
  - is_mret_mw=1, irq_pending=1 and br_taken_ex=1 together → mret_take only, then redirect to mepc=0x80.
  - trap_take fires only after the return to RUN.
- Mid-operation reset: reset asserted in TRAP → next cycle state RUN, redirect=0, all outputs 0.
